// File: rtl/tlx_fwd_credit_tx.sv
// tlx_fwd_credit_tx: credit-gated FIFO transmit stage for the TLX forward payload stream.
// Define TLX_FWD_CREDIT_ERR_EN to make CREDIT_ERR a sticky credit-overflow flag; otherwise it is tied low.
module tlx_fwd_credit_tx #(
  parameter int DEPTH = 4,
  parameter int MAX_CREDITS = 8,
  parameter int INIT_CREDITS = 8,
  localparam int CW = $clog2(MAX_CREDITS + 1)
) (
  input  logic          FWD_CLK,
  input  logic          FWD_RESET,
  input  logic          IN_TVALID,
  output logic          IN_TREADY,
  input  logic [39:0]   IN_TDATA,
  output logic          FWD_PAYLOAD_TVALID,
  output logic [39:0]   FWD_PAYLOAD_TDATA,
  input  logic          CREDIT_TVALID,
  input  logic [2:0]    CREDIT_TDATA,
  output logic [CW-1:0] CREDIT_COUNT,
  output logic          CREDIT_ERR
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 4;
  logic [39:0]   mem [DEPTH];
  logic [AW:0]   wp, rp, wp_n, rp_n;
  logic [SW-1:0] sum;
  logic          empty, issue, push, ovf;
  assign empty = wp == rp;
  assign issue = !empty && CREDIT_COUNT != '0;
  assign push  = IN_TVALID && IN_TREADY;
  assign wp_n  = wp + {{AW{1'b0}}, push};
  assign rp_n  = rp + {{AW{1'b0}}, issue};
  // wide enough that count plus a full return never wraps before the saturation test
  assign sum   = SW'(CREDIT_COUNT) - SW'(issue) + (CREDIT_TVALID ? SW'(CREDIT_TDATA) : SW'(0));
  assign ovf   = sum > SW'(MAX_CREDITS);
  always_ff @(posedge FWD_CLK or posedge FWD_RESET) begin
    if (FWD_RESET) begin
      wp <= '0;
      rp <= '0;
      IN_TREADY <= 1'b0;
      FWD_PAYLOAD_TVALID <= 1'b0;
      FWD_PAYLOAD_TDATA <= '0;
      CREDIT_COUNT <= CW'(INIT_CREDITS);
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      IN_TREADY <= (wp_n ^ rp_n) != {1'b1, {AW{1'b0}}};
      FWD_PAYLOAD_TVALID <= issue;
      if (issue) FWD_PAYLOAD_TDATA <= mem[rp[AW-1:0]];
      CREDIT_COUNT <= ovf ? CW'(MAX_CREDITS) : sum[CW-1:0];
    end
  end
  always_ff @(posedge FWD_CLK) begin
    if (push) mem[wp[AW-1:0]] <= IN_TDATA;
  end
`ifdef TLX_FWD_CREDIT_ERR_EN
  always_ff @(posedge FWD_CLK or posedge FWD_RESET) begin
    if (FWD_RESET) CREDIT_ERR <= 1'b0;
    else if (ovf) CREDIT_ERR <= 1'b1;
  end
`else
  assign CREDIT_ERR = 1'b0;
`endif
endmodule

// File: doc/tlx_fwd_credit_tx.md
# tlx_fwd_credit_tx

Credit-gated transmit stage for the TLX forward payload stream. Sits directly upstream of the forward link: buffers 40-bit payload words from the AXI-to-TLX packer and issues them on FWD_PAYLOAD_TVALID/TDATA only while the far end has advertised buffer credits. Credits are consumed one per issued word and replenished by credit-return beats that arrive already synchronized into the FWD_CLK domain.

## Interface
- DEPTH, 4, FIFO depth in 40-bit words; power of two, ≥2
- MAX_CREDITS, 8, credit counter ceiling; 1..15
- INIT_CREDITS, 8, credit count after reset; ≤ MAX_CREDITS
- CW, derived = $clog2(MAX_CREDITS+1), credit counter width

Ports:
- FWD_CLK  in  1  sole clock, rising edge
- FWD_RESET  in  1  asynchronous, active-high reset
- IN_TVALID  in  1  upstream word valid
- IN_TREADY  out  1  FIFO can accept a word this cycle
- IN_TDATA  in  40  upstream payload word
- FWD_PAYLOAD_TVALID  out  1  issued word valid; no backpressure, the link always consumes
- FWD_PAYLOAD_TDATA  out  40  issued word
- CREDIT_TVALID  in  1  credit-return beat valid
- CREDIT_TDATA  in  3  credits returned by this beat, 0..7
- CREDIT_COUNT  out  CW  current credit count
- CREDIT_ERR  out  1  sticky credit-overflow flag

## Operation
- FIFO: DEPTH entries, read/write pointers of log2(DEPTH)+1 bits; full when pointers differ only in MSB, empty when equal. Pointers wrap modulo 2·DEPTH.
- Push: IN_TVALID & IN_TREADY at rising edge. IN_TREADY = !full, from registered state only; a pop in the same cycle does not create room that cycle.
- Issue: at each rising edge, if FIFO non-empty and CREDIT_COUNT > 0, pop head into output register and set FWD_PAYLOAD_TVALID=1 for that cycle; otherwise FWD_PAYLOAD_TVALID=0, FWD_PAYLOAD_TDATA holds its last value.
- At most one word issued per cycle; words leave in acceptance order.
- Credit update per edge: next = CREDIT_COUNT − issue + (CREDIT_TVALID ? CREDIT_TDATA : 0), computed at CW+1 bits. If next > MAX_CREDITS, CREDIT_COUNT saturates to MAX_CREDITS and an overflow event occurs.
- Simultaneous issue and return apply in the same cycle (e.g. count 0, return 1, no issue possible that edge since issue requires count>0 beforehand; count becomes 1).
- Returns of CREDIT_TDATA=0 with CREDIT_TVALID=1 are legal no-ops.
- Reset (asserted at any time, including mid-burst): FIFO flushed, pointers 0, CREDIT_COUNT=INIT_CREDITS, FWD_PAYLOAD_TVALID=0, FWD_PAYLOAD_TDATA=0, CREDIT_ERR=0, IN_TREADY=0 while FWD_RESET high, 1 after release.

## Timing
- Word accepted at edge k, FIFO previously empty, credits available: FWD_PAYLOAD_TVALID high in the cycle after edge k+1 (1-cycle latency edge-to-edge).
- Back-to-back: with credits ≥ N and steady input, N words issue on N consecutive cycles.
- Credit return at edge k is usable for an issue at edge k+1.
- CREDIT_COUNT, CREDIT_ERR, IN_TREADY are registered outputs; FWD_PAYLOAD_* registered.

## Configuration
- TLX_FWD_CREDIT_ERR_EN defined: CREDIT_ERR sets on any overflow event and stays set until reset.
- Not defined: CREDIT_ERR tied to 0; saturation of CREDIT_COUNT still applies.

## Test plan
- Reset, INIT_CREDITS=8, push 3 words 0xA0..0xA2 on consecutive edges -> issued 0xA0,0xA1,0xA2 on consecutive cycles starting 1 cycle after first accept; CREDIT_COUNT ends 5.
- Push 12 words with no credit return -> exactly 8 issued, FIFO holds 4, IN_TREADY=0 (DEPTH=4), CREDIT_COUNT=0; then return 3 credits -> next 3 words issue, IN_TREADY reasserts.
- Credit count 7, one issue plus return of 2 in the same edge -> CREDIT_COUNT=8, CREDIT_ERR stays 0.
- Credit count 8, return 5 with no issue -> CREDIT_COUNT=8; CREDIT_ERR=1 and sticky if TLX_FWD_CREDIT_ERR_EN, else 0.
- Assert FWD_RESET with 3 words queued and count 2 -> next cycle no FWD_PAYLOAD_TVALID, CREDIT_COUNT=8, queued words never issued.
- Random push/return traffic 10k cycles -> scoreboard order intact, issued total ≤ INIT_CREDITS + returned credits.
